// File: rtl/dmu_sii_chk_pkg.sv
// Shared types and constants for the DMU-to-SII inbound request checker.
package dmu_sii_chk_pkg;

    localparam int PAR_GRP = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_PAY,
        ST_M_PAY
    } state_e;

    typedef enum logic [2:0] {
        REQ_RD,
        REQ_WR,
        REQ_MONDO,
        REQ_PIO,
        REQ_ILL
    } req_e;

    function automatic req_e classify(input logic bypass, input logic datareq, input logic datareq16);
        req_e r;
        case ({datareq, datareq16})
            2'b00:   r = REQ_RD;
            2'b10:   r = REQ_WR;
            2'b11:   r = bypass ? REQ_PIO : REQ_MONDO;
            default: r = REQ_ILL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmu_sii_par_chk.sv
// Per-16-bit even-parity mismatch detector for the DMU-to-SII data bus.
module dmu_sii_par_chk
    import dmu_sii_chk_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic [DATA_W-1:0]         data,
    input  logic [DATA_W/PAR_GRP-1:0] parity,
    output logic                      mismatch
);

    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < DATA_W / PAR_GRP; i++) begin
            if ((^data[i*PAR_GRP +: PAR_GRP]) != parity[i]) mismatch = 1'b1;
        end
    end

endmodule

// File: rtl/dmu_sii_inbound_chk.sv
// DMU-to-SII inbound protocol checker: header classification, payload tracking, write credits.
// Define PARITY_CHK_EN to enable per-16-bit parity checking on header and payload beats.
module dmu_sii_inbound_chk
    import dmu_sii_chk_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int WR_BEATS = 4,
    parameter int CREDITS  = 16,
    parameter int CNT_W    = 16
) (
    input  logic                         iol2clk,
    input  logic                         rst_l,
    input  logic                         dmu_sii_hdr_vld,
    input  logic                         dmu_sii_reqbypass,
    input  logic                         dmu_sii_datareq,
    input  logic                         dmu_sii_datareq16,
    input  logic [DATA_W-1:0]            dmu_sii_data,
    input  logic [DATA_W/16-1:0]         dmu_sii_parity,
    input  logic                         sii_dmu_wrack_vld,
    input  logic                         clr,
    output logic [CNT_W-1:0]             rd_cnt,
    output logic [CNT_W-1:0]             wr_cnt,
    output logic [CNT_W-1:0]             mondo_cnt,
    output logic [CNT_W-1:0]             pio_cnt,
    output logic [$clog2(CREDITS+1)-1:0] credit_avail,
    output logic                         err_proto,
    output logic                         err_credit,
    output logic                         err_parity,
    output logic                         busy
);

    localparam int CR_W   = $clog2(CREDITS + 1);
    localparam int BEAT_W = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WR_BEATS - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e            state, state_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_nxt;
    logic [CR_W-1:0]   credit_nxt;
    req_e              req;
    logic              hdr_idle, accept, take_wr, proto_evt, credit_evt;

    always_comb begin
        req       = classify(dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16);
        hdr_idle  = dmu_sii_hdr_vld && (state == ST_IDLE);
        accept    = hdr_idle && (req != REQ_ILL);
        take_wr   = accept && (req == REQ_WR);
        // Any header seen while a payload is in flight is a protocol error and is dropped.
        proto_evt = dmu_sii_hdr_vld && ((state != ST_IDLE) || (req == REQ_ILL));
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        case (state)
            ST_IDLE: begin
                beat_nxt = '0;
                if (accept) begin
                    case (req)
                        REQ_WR:           state_nxt = ST_WR_PAY;
                        REQ_MONDO,
                        REQ_PIO:          state_nxt = ST_M_PAY;
                        default:          state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_WR_PAY: begin
                if (beat_cnt == LAST_BEAT) begin
                    state_nxt = ST_IDLE;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat_cnt + 1'b1;
                end
            end
            ST_M_PAY: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A write header and a same-cycle return cancel out, so an empty pool is not an error then.
    always_comb begin
        credit_nxt = credit_avail;
        credit_evt = 1'b0;
        case ({take_wr, sii_dmu_wrack_vld})
            2'b10: begin
                if (credit_avail == '0) credit_evt = 1'b1;
                else                    credit_nxt = credit_avail - 1'b1;
            end
            2'b01: begin
                if (credit_avail == CR_W'(CREDITS)) credit_evt = 1'b1;
                else                                credit_nxt = credit_avail + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iol2clk) begin
        if (!rst_l) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            busy         <= 1'b0;
            credit_avail <= CR_W'(CREDITS);
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            mondo_cnt    <= '0;
            pio_cnt      <= '0;
            err_proto    <= 1'b0;
            err_credit   <= 1'b0;
        end else begin
            state        <= state_nxt;
            beat_cnt     <= beat_nxt;
            busy         <= (state_nxt != ST_IDLE);
            credit_avail <= credit_nxt;
            if (clr) begin
                rd_cnt     <= '0;
                wr_cnt     <= '0;
                mondo_cnt  <= '0;
                pio_cnt    <= '0;
                err_proto  <= 1'b0;
                err_credit <= 1'b0;
            end else begin
                if (accept && req == REQ_RD)    rd_cnt    <= sat_inc(rd_cnt);
                if (take_wr)                    wr_cnt    <= sat_inc(wr_cnt);
                if (accept && req == REQ_MONDO) mondo_cnt <= sat_inc(mondo_cnt);
                if (accept && req == REQ_PIO)   pio_cnt   <= sat_inc(pio_cnt);
                if (proto_evt)                  err_proto  <= 1'b1;
                if (credit_evt)                 err_credit <= 1'b1;
            end
        end
    end

`ifdef PARITY_CHK_EN
    logic par_mismatch;

    dmu_sii_par_chk #(
        .DATA_W (DATA_W)
    ) u_par_chk (
        .data     (dmu_sii_data),
        .parity   (dmu_sii_parity),
        .mismatch (par_mismatch)
    );

    // Header beats and every payload beat are covered.
    always_ff @(posedge iol2clk) begin
        if (!rst_l)  err_parity <= 1'b0;
        else if (clr) err_parity <= 1'b0;
        else if (par_mismatch && (dmu_sii_hdr_vld || state != ST_IDLE)) err_parity <= 1'b1;
    end
`else
    logic unused_bus;
    assign unused_bus = ^{dmu_sii_data, dmu_sii_parity};
    assign err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_dmu_sii_inbound_chk.sv
// Directed scoreboard bench for dmu_sii_inbound_chk (parity cases follow PARITY_CHK_EN).
module tb_dmu_sii_inbound_chk;

    localparam int DATA_W   = 128;
    localparam int WR_BEATS = 4;
    localparam int CREDITS  = 16;
    localparam int CNT_W    = 5;
    localparam int MAXC     = (1 << CNT_W) - 1;
    localparam int CR_W     = $clog2(CREDITS + 1);

    logic                 iol2clk = 1'b0;
    logic                 rst_l = 1'b0, hdr_vld = 1'b0, reqbypass = 1'b0;
    logic                 datareq = 1'b0, datareq16 = 1'b0, wrack = 1'b0, clr = 1'b0;
    logic [DATA_W-1:0]    data = '0;
    logic [DATA_W/16-1:0] parity = '0;
    logic [CNT_W-1:0]     rd_cnt, wr_cnt, mondo_cnt, pio_cnt;
    logic [CR_W-1:0]      credit_avail;
    logic                 err_proto, err_credit, err_parity, busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int rd, wr, mo, pio, cr;
        bit ep, ec, epar, busy;
    } exp_t;
    exp_t q[$];

    // Reference model state
    int m_st, m_left, m_rd, m_wr, m_mo, m_pio, m_cr;
    bit m_ep, m_ec, m_epar, m_busy;

    always #5 iol2clk = ~iol2clk;

    dmu_sii_inbound_chk #(
        .DATA_W   (DATA_W),
        .WR_BEATS (WR_BEATS),
        .CREDITS  (CREDITS),
        .CNT_W    (CNT_W)
    ) dut (
        .iol2clk           (iol2clk),
        .rst_l             (rst_l),
        .dmu_sii_hdr_vld   (hdr_vld),
        .dmu_sii_reqbypass (reqbypass),
        .dmu_sii_datareq   (datareq),
        .dmu_sii_datareq16 (datareq16),
        .dmu_sii_data      (data),
        .dmu_sii_parity    (parity),
        .sii_dmu_wrack_vld (wrack),
        .clr               (clr),
        .rd_cnt            (rd_cnt),
        .wr_cnt            (wr_cnt),
        .mondo_cnt         (mondo_cnt),
        .pio_cnt           (pio_cnt),
        .credit_avail      (credit_avail),
        .err_proto         (err_proto),
        .err_credit        (err_credit),
        .err_parity        (err_parity),
        .busy              (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model(input bit h, input bit [1:0] dq, input bit byp, input bit wk,
                         input bit c, input bit r, input bit flip);
        bit in_pay, wr_hdr, bad, cerr;
        if (!r) begin
            m_st = 0; m_left = 0;
            m_rd = 0; m_wr = 0; m_mo = 0; m_pio = 0;
            m_cr = CREDITS;
            m_ep = 0; m_ec = 0; m_epar = 0; m_busy = 0;
        end else begin
            in_pay = (m_st != 0);
            wr_hdr = 0; bad = 0; cerr = 0;
            if (in_pay) begin
                if (h) bad = 1;
                m_left--;
                if (m_left == 0) m_st = 0;
            end else if (h) begin
                case (dq)
                    2'b00: if (m_rd < MAXC) m_rd++;
                    2'b10: begin
                        wr_hdr = 1;
                        if (m_wr < MAXC) m_wr++;
                        m_st = 1; m_left = WR_BEATS;
                    end
                    2'b11: begin
                        if (byp) begin if (m_pio < MAXC) m_pio++; end
                        else begin if (m_mo < MAXC) m_mo++; end
                        m_st = 2; m_left = 1;
                    end
                    default: bad = 1;
                endcase
            end
            if (wr_hdr && !wk) begin
                if (m_cr == 0) cerr = 1; else m_cr--;
            end else if (wk && !wr_hdr) begin
                if (m_cr == CREDITS) cerr = 1; else m_cr++;
            end
            if (bad)  m_ep = 1;
            if (cerr) m_ec = 1;
`ifdef PARITY_CHK_EN
            if (flip && (h || in_pay)) m_epar = 1;
`endif
            if (c) begin
                m_rd = 0; m_wr = 0; m_mo = 0; m_pio = 0;
                m_ep = 0; m_ec = 0; m_epar = 0;
            end
            m_busy = (m_st != 0);
        end
    endtask

    task automatic cyc(input bit h, input bit [1:0] dq, input bit byp, input bit wk,
                       input bit c, input bit r, input bit flip);
        exp_t e;
        hdr_vld = h; datareq = dq[1]; datareq16 = dq[0]; reqbypass = byp;
        wrack = wk; clr = c; rst_l = r;
        for (int i = 0; i < DATA_W / 32; i++) data[i*32 +: 32] = $urandom;
        for (int i = 0; i < DATA_W / 16; i++) parity[i] = ^data[i*16 +: 16];
        if (flip) parity[3] = ~parity[3];
        model(h, dq, byp, wk, c, r, flip);
        e.rd = m_rd; e.wr = m_wr; e.mo = m_mo; e.pio = m_pio; e.cr = m_cr;
        e.ep = m_ep; e.ec = m_ec; e.epar = m_epar; e.busy = m_busy;
        q.push_back(e);
        @(posedge iol2clk);
        #1;
        e = q.pop_front();
        chk("rd_cnt",       rd_cnt,       e.rd);
        chk("wr_cnt",       wr_cnt,       e.wr);
        chk("mondo_cnt",    mondo_cnt,    e.mo);
        chk("pio_cnt",      pio_cnt,      e.pio);
        chk("credit_avail", credit_avail, e.cr);
        chk("err_proto",    err_proto,    e.ep);
        chk("err_credit",   err_credit,   e.ec);
        chk("err_parity",   err_parity,   e.epar);
        chk("busy",         busy,         e.busy);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 2'b00, 0, 0, 0, 1, 0);
    endtask

    task automatic hdr(input bit [1:0] dq, input bit byp);
        cyc(1, dq, byp, 0, 0, 1, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset
        cyc(0, 2'b00, 0, 0, 0, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0);
        chk("reset_credit", credit_avail, 16);
        chk("reset_busy", busy, 0);
        chk("reset_rd", rd_cnt, 0);

        // Read, write + 4 beats, mondo right after last beat + 1 beat
        hdr(2'b00, 0);
        hdr(2'b10, 0);
        idle(4);
        hdr(2'b11, 0);
        idle(2);
        chk("seq_rd", rd_cnt, 1);
        chk("seq_wr", wr_cnt, 1);
        chk("seq_mondo", mondo_cnt, 1);
        chk("seq_credit", credit_avail, 15);
        chk("seq_err", {err_proto, err_credit, err_parity}, 0);

        // PIO read return, then illegal header, then clear
        hdr(2'b11, 1);
        idle(1);
        chk("pio_cnt", pio_cnt, 1);
        hdr(2'b01, 0);
        chk("illegal_proto", err_proto, 1);
        chk("illegal_rd_unchanged", rd_cnt, 1);
        cyc(0, 2'b00, 0, 0, 1, 1, 0);
        chk("clr_proto", err_proto, 0);
        chk("clr_credit_kept", credit_avail, 15);

        // Header during last write beat is dropped; next header accepted
        hdr(2'b10, 0);
        idle(3);
        cyc(1, 2'b10, 0, 0, 0, 1, 0);
        chk("beat4_proto", err_proto, 1);
        chk("beat4_wr", wr_cnt, 1);
        chk("beat4_credit", credit_avail, 14);
        chk("beat4_busy", busy, 0);
        hdr(2'b00, 0);
        chk("after_last_rd", rd_cnt, 1);
        idle(1);

        // Credit exhaustion
        cyc(0, 2'b00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            hdr(2'b10, 0);
            idle(4);
        end
        chk("cr_empty", credit_avail, 0);
        chk("cr_empty_err", err_credit, 0);
        hdr(2'b10, 0);
        chk("cr_17th_err", err_credit, 1);
        chk("cr_17th_val", credit_avail, 0);
        idle(4);

        // Write header with wrack at zero credit
        cyc(0, 2'b00, 0, 0, 1, 1, 0);
        cyc(1, 2'b10, 0, 1, 0, 1, 0);
        chk("wr_wrack_credit", credit_avail, 0);
        chk("wr_wrack_err", err_credit, 0);
        idle(4);
        repeat (16) cyc(0, 2'b00, 0, 1, 0, 1, 0);
        chk("cr_full", credit_avail, 16);
        chk("cr_full_err", err_credit, 0);
        cyc(0, 2'b00, 0, 1, 0, 1, 0);
        chk("cr_over_err", err_credit, 1);
        chk("cr_over_val", credit_avail, 16);

        // Parity error on payload beat 2, then clear
        cyc(0, 2'b00, 0, 0, 1, 1, 0);
        hdr(2'b10, 0);
        idle(1);
        cyc(0, 2'b00, 0, 0, 0, 1, 1);
        idle(2);
`ifdef PARITY_CHK_EN
        chk("par_err", err_parity, 1);
`else
        chk("par_tied", err_parity, 0);
`endif
        cyc(0, 2'b00, 0, 0, 1, 1, 0);
        chk("par_clr_errs", {err_proto, err_credit, err_parity}, 0);
        chk("par_clr_wr", wr_cnt, 0);
        chk("par_clr_credit", credit_avail, 15);

        // clr beats same-cycle count and error events
        cyc(1, 2'b00, 0, 0, 1, 1, 0);
        chk("clr_prio_rd", rd_cnt, 0);
        cyc(1, 2'b01, 0, 0, 1, 1, 0);
        chk("clr_prio_proto", err_proto, 0);

        // Counter saturation
        repeat (MAXC + 4) hdr(2'b00, 0);
        chk("rd_saturate", rd_cnt, MAXC);

        // Reset during write beat 2
        hdr(2'b10, 0);
        idle(1);
        cyc(0, 2'b00, 0, 0, 0, 0, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_credit", credit_avail, 16);
        chk("rst_mid_cnt", {rd_cnt, wr_cnt}, 0);
        hdr(2'b00, 0);
        chk("rst_mid_idle_rd", rd_cnt, 1);
        hdr(2'b10, 0);
        chk("rst_mid_wr_busy", busy, 1);
        idle(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmu_sii_inbound_chk.md
DMU_SII_INBOUND_CHK -- requirements
Module: dmu_sii_inbound_chk

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter DATA_W, default 128, SHALL set the DMU-to-SII data bus width (multiple of 16).
REQ-003 Parameter WR_BEATS, default 4, SHALL set the number of DMA write payload beats.
REQ-004 Parameter CREDITS, default 16, SHALL set the DMA write credit pool size.
REQ-005 Parameter CNT_W, default 16, SHALL set the event counter width.
REQ-006 iol2clk  in  1  SHALL be the clock.
REQ-007 rst_l  in  1  SHALL be the synchronous active-low reset.
REQ-008 dmu_sii_hdr_vld  in  1  SHALL mark a header cycle.
REQ-009 dmu_sii_reqbypass / dmu_sii_datareq / dmu_sii_datareq16  in  1 each  SHALL be the request qualifiers.
REQ-010 dmu_sii_data  in  DATA_W  SHALL carry header or payload; dmu_sii_parity  in  DATA_W/16  SHALL carry per-16-bit parity.
REQ-011 sii_dmu_wrack_vld  in  1  SHALL be a one-credit write return.
REQ-012 clr  in  1  SHALL clear counters and sticky errors.
REQ-013 rd_cnt, wr_cnt, mondo_cnt, pio_cnt  out  CNT_W each  SHALL count accepted headers per type.
REQ-014 credit_avail  out  $clog2(CREDITS+1)  SHALL give the available write credits.
REQ-015 err_proto, err_credit, err_parity, busy  out  1 each  SHALL be the sticky error flags and the payload-in-progress flag.

Function
REQ-016 Header classification SHALL be: datareq=0,datareq16=0 read; datareq=1,datareq16=0 write; datareq=1,datareq16=1 with reqbypass=0 mondo, with reqbypass=1 PIO read return; datareq=0,datareq16=1 illegal, which sets err_proto and is not counted.
REQ-017 The FSM SHALL have states IDLE, WR_PAY and M_PAY; busy SHALL be 1 outside IDLE.
REQ-018 In IDLE, a read header SHALL stay in IDLE, a write header SHALL go to WR_PAY, and a mondo or PIO header SHALL go to M_PAY.
REQ-019 WR_PAY SHALL treat every cycle as a payload beat with no gaps and return to IDLE after WR_BEATS beats; M_PAY SHALL last exactly one beat.
REQ-020 hdr_vld in any payload beat, including the last, SHALL set err_proto; that header SHALL be ignored (not counted, no credit effect).
REQ-021 A header in the cycle after the last payload beat SHALL be accepted normally.
REQ-022 An accepted write header SHALL decrement credit_avail; with credit_avail=0 it SHALL set err_credit and leave credit_avail at 0.
REQ-023 A wrack SHALL increment credit_avail; with credit_avail=CREDITS it SHALL set err_credit and hold the value.
REQ-024 A write header and a wrack in the same cycle SHALL leave credit_avail unchanged with no error, including when credit_avail=0.
REQ-025 Counters SHALL saturate at all-ones.
REQ-026 All outputs SHALL be registered and update on the edge that samples the causing input.
REQ-027 clr SHALL zero the counters and error flags and SHALL NOT affect the FSM or credit_avail.
REQ-028 clr SHALL take priority over a same-cycle count or error event.

Reset
REQ-029 With rst_l=0 sampled, the block SHALL set state IDLE, all counters 0, credit_avail=CREDITS, all err_* 0 and busy 0.
REQ-030 Reset mid-payload SHALL abandon the payload, and the next cycle SHALL start in IDLE.

Configuration
REQ-031 With PARITY_CHK_EN defined, on every header and payload beat, mismatch of dmu_sii_parity[i] against XOR of dmu_sii_data[16i+15:16i] SHALL set err_parity.
REQ-032 Without PARITY_CHK_EN, err_parity SHALL be tied to 0 and no parity logic SHALL be present.

Structure
REQ-033 Package dmu_sii_chk_pkg SHALL hold the FSM state enum, the request-type enum and the constant PAR_GRP=16.
REQ-034 Sub-module dmu_sii_par_chk SHALL compute the parity mismatch and SHALL be instantiated only under PARITY_CHK_EN.

Verification
REQ-035 Read header, then write header plus 4 beats, then mondo header plus 1 beat -> rd_cnt=1, wr_cnt=1, mondo_cnt=1, credit_avail=15, busy high for 4 cycles then 1 cycle, no errors.
REQ-036 17 write transactions with no wrack -> credit_avail reaches 0; the 17th sets err_credit; wrack at credit 16 also sets err_credit.
REQ-037 hdr_vld during beat 4 of a write payload -> err_proto=1, header not counted, FSM returns to IDLE on schedule.
REQ-038 Write header with simultaneous wrack at credit_avail=0 -> credit_avail stays 0, err_credit=0.
REQ-039 With PARITY_CHK_EN, flip dmu_sii_parity[3] on payload beat 2 -> err_parity=1; clr then pulsed -> all errors and counters 0, credit_avail unchanged.
REQ-040 Assert rst_l=0 during beat 2 of a write payload -> next cycle busy=0, credit_avail=16, counters 0.
